// File: rtl/window_buf_kxk.sv
// rtl/window_buf_kxk.sv - KxK sliding window buffer over a raster pixel stream
//
// Takes a raster-order pixel stream and presents one full KxK window per
// output position. The window step is STRIDE in both directions, and frames
// follow each other with no gap between them.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   in_valid       in_data holds a pixel
//   in_ready       block can take a pixel (low while rst, or while a window is held)
//   in_data        pixel, raster order
//   out_valid      out_window/out_row/out_col/out_last are valid
//   out_ready      consumer takes the window
//   out_window     element (i*K+j) = pixel(r+i, c+j), element 0 in the LSBs
//   out_row        top-left row r of the window
//   out_col        top-left col c of the window
//   out_last       final window of the frame
module window_buf_kxk #(
    parameter int DATA_BITS = 12,
    parameter int IMG_W     = 12,
    parameter int IMG_H     = 12,
    parameter int K         = 5,
    parameter int STRIDE    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_BITS-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*DATA_BITS-1:0]     out_window,
    output logic [$clog2(IMG_H)-1:0]     out_row,
    output logic [$clog2(IMG_W)-1:0]     out_col,
    output logic                         out_last
);

    localparam int RW     = $clog2(IMG_H);
    localparam int CW     = $clog2(IMG_W);
    localparam int SW     = (K > 1) ? $clog2(K) : 1;
    localparam int PHW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int R_LAST = ((IMG_H - K) / STRIDE) * STRIDE;
    localparam int C_LAST = ((IMG_W - K) / STRIDE) * STRIDE;

    if (K > IMG_W) begin : g_err_kw
        $error("window_buf_kxk: K exceeds IMG_W");
    end
    if (K > IMG_H) begin : g_err_kh
        $error("window_buf_kxk: K exceeds IMG_H");
    end
    if (STRIDE < 1 || STRIDE > K) begin : g_err_stride
        $error("window_buf_kxk: STRIDE must be in 1..K");
    end

    // K row slots used as a ring: K-1 completed rows plus the row being filled.
    logic [DATA_BITS-1:0]     line_mem [K][IMG_W];
    logic [RW-1:0]            row;
    logic [CW-1:0]            col;
    logic [SW-1:0]            slot;
    // Stride phases hold (row-K+1)%STRIDE and (col-K+1)%STRIDE once past K-1,
    // which avoids a modulo in the emit path.
    logic [PHW-1:0]           row_ph;
    logic [PHW-1:0]           col_ph;
    logic                     accept;
    logic                     emit;
    logic [K*K*DATA_BITS-1:0] win_next;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = (int'(row) >= K - 1) && (int'(col) >= K - 1) &&
                      (row_ph == '0) && (col_ph == '0);

    // Window row i lives in slot (slot - (K-1) + i) mod K, i.e. (slot+1+i) mod K.
    function automatic logic [SW-1:0] slot_of(input logic [SW-1:0] cur, input int i);
        int t;
        t = int'(cur) + 1 + i;
        if (t >= K) t = t - K;
        return SW'(t);
    endfunction

    // Clamped so that non-emitting positions never index below column 0.
    function automatic logic [CW-1:0] col_of(input logic [CW-1:0] cur, input int j);
        int t;
        t = int'(cur) - (K - 1) + j;
        if (t < 0) t = 0;
        return CW'(t);
    endfunction

    // The bottom-right element is the pixel arriving now; it is not in storage yet.
    always_comb begin
        win_next = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                if (i == K - 1 && j == K - 1)
                    win_next[(i*K+j)*DATA_BITS +: DATA_BITS] = in_data;
                else
                    win_next[(i*K+j)*DATA_BITS +: DATA_BITS] =
                        line_mem[slot_of(slot, i)][col_of(col, j)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            line_mem[slot][col] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            slot   <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (accept) begin
            if (int'(col) == IMG_W - 1) begin
                col    <= '0;
                col_ph <= '0;
                if (int'(row) == IMG_H - 1) begin
                    // Frame wrap: next pixel is (0,0) of the following frame.
                    row    <= '0;
                    row_ph <= '0;
                    slot   <= '0;
                end else begin
                    row  <= row + 1'b1;
                    slot <= (int'(slot) == K - 1) ? '0 : slot + 1'b1;
                    if (int'(row) >= K - 1)
                        row_ph <= (int'(row_ph) == STRIDE - 1) ? '0 : row_ph + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                if (int'(col) >= K - 1)
                    col_ph <= (int'(col_ph) == STRIDE - 1) ? '0 : col_ph + 1'b1;
            end
        end
    end

    // A pixel is only accepted when the output slot is free or draining, so an
    // accept either loads a new window or retires the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
        end else if (accept) begin
            if (emit) begin
                out_valid  <= 1'b1;
                out_window <= win_next;
                out_row    <= RW'(int'(row) - (K - 1));
                out_col    <= CW'(int'(col) - (K - 1));
                out_last   <= (int'(row) - (K - 1) == R_LAST) &&
                              (int'(col) - (K - 1) == C_LAST);
            end else begin
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_buf_kxk.sv
// tb/tb_window_buf_kxk.sv - directed bench for window_buf_kxk
module tb_window_buf_kxk;

    localparam int DB = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [DB-1:0] in_data;
    int         sel;
    logic       sel_rdy;

    logic         a_in_ready, a_out_valid, a_out_last;
    logic [299:0] a_out_window;
    logic [3:0]   a_out_row, a_out_col;
    logic         b_in_ready, b_out_valid, b_out_last;
    logic [299:0] b_out_window;
    logic [3:0]   b_out_row, b_out_col;
    logic         c_in_ready, c_out_valid, c_out_last;
    logic [107:0] c_out_window;
    logic [2:0]   c_out_row, c_out_col;

    always #5 clk = ~clk;

    window_buf_kxk #(.DATA_BITS(DB), .IMG_W(12), .IMG_H(12), .K(5), .STRIDE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_window(a_out_window), .out_row(a_out_row), .out_col(a_out_col),
        .out_last(a_out_last));

    window_buf_kxk #(.DATA_BITS(DB), .IMG_W(12), .IMG_H(12), .K(5), .STRIDE(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_window(b_out_window), .out_row(b_out_row), .out_col(b_out_col),
        .out_last(b_out_last));

    window_buf_kxk #(.DATA_BITS(DB), .IMG_W(8), .IMG_H(6), .K(3), .STRIDE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_window(c_out_window), .out_row(c_out_row), .out_col(c_out_col),
        .out_last(c_out_last));

    assign sel_rdy = (sel == 0) ? a_in_ready : (sel == 1) ? b_in_ready : c_in_ready;

    typedef struct {
        logic [319:0] win;
        int           row;
        int           col;
        int           last;
    } cap_t;

    cap_t       cap [3][$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [DB-1:0] pix [288];

    always @(negedge clk) begin
        cap_t e;
        if (!rst && out_ready) begin
            if (a_out_valid) begin
                e.win = 320'(a_out_window); e.row = int'(a_out_row);
                e.col = int'(a_out_col);    e.last = int'(a_out_last);
                cap[0].push_back(e);
            end
            if (b_out_valid) begin
                e.win = 320'(b_out_window); e.row = int'(b_out_row);
                e.col = int'(b_out_col);    e.last = int'(b_out_last);
                cap[1].push_back(e);
            end
            if (c_out_valid) begin
                e.win = 320'(c_out_window); e.row = int'(c_out_row);
                e.col = int'(c_out_col);    e.last = int'(c_out_last);
                cap[2].push_back(e);
            end
        end
    end

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] exp_win(input int off, input int r, input int c,
                                             input int k, input int w);
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                v[(i*k+j)*DB +: DB] = pix[off + (r+i)*w + c + j];
        return v;
    endfunction

    // Called and returns at posedge+1. Feeds pix[lo..hi-1] to the selected instance.
    task automatic drive(input int lo, input int hi, input bit rnd);
        int idx;
        int cyc;
        bit acc;
        idx = lo;
        cyc = 0;
        while (idx < hi && cyc < 20000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pix[idx];
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && sel_rdy;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        if (rnd) out_ready = 1'b1;
        chk("drive_done", idx, hi);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int q = 0; q < 3; q++) cap[q].delete();
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic chk_seq(input int q, input int off0, input int nf, input int k,
                           input int w, input int h, input int s);
        int nr, nc, n, r, c;
        cap_t e;
        nr = (h - k) / s + 1;
        nc = (w - k) / s + 1;
        n = 0;
        chk("count", cap[q].size(), nf * nr * nc);
        for (int f = 0; f < nf; f++)
            for (int ri = 0; ri < nr; ri++)
                for (int ci = 0; ci < nc; ci++) begin
                    if (n < cap[q].size()) begin
                        r = ri * s;
                        c = ci * s;
                        e = cap[q][n];
                        chk("window", e.win, exp_win(off0 + f*w*h, r, c, k, w));
                        chk("tag_row_col_last", {e.row[15:0], e.col[15:0], e.last[0]},
                            {16'(r), 16'(c), (ri == nr-1 && ci == nc-1)});
                    end
                    n++;
                end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; sel = 0;
        for (int k = 0; k < 144; k++) begin
            pix[k]       = DB'(k);
            pix[144 + k] = DB'(1000 + k);
        end

        @(posedge clk); #1;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_window", a_out_window, 0);
        chk("rst_out_row", a_out_row, 0);
        chk("rst_out_col", a_out_col, 0);
        chk("rst_out_last", a_out_last, 0);

        // Ramp frame, defaults: first window latency, then all 64 windows.
        do_reset();
        sel = 0;
        drive(0, 52, 0);
        @(negedge clk);
        chk("pre_first_valid", a_out_valid, 0);
        @(posedge clk); #1;
        drive(52, 53, 0);
        @(negedge clk);
        chk("first_valid", a_out_valid, 1);
        chk("first_elem0", a_out_window[11:0], 0);
        chk("first_elem24", a_out_window[299:288], 52);
        chk("first_row", a_out_row, 0);
        chk("first_col", a_out_col, 0);
        @(posedge clk); #1;
        drive(53, 144, 0);
        settle();
        chk_seq(0, 0, 1, 5, 12, 12, 1);

        // STRIDE=2.
        do_reset();
        sel = 1;
        drive(0, 144, 0);
        settle();
        chk_seq(1, 0, 1, 5, 12, 12, 2);

        // Backpressure on the first window.
        do_reset();
        sel = 0;
        out_ready = 1'b0;
        fork
            drive(0, 144, 0);
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!a_out_valid && w < 1000) begin
                    @(negedge clk);
                    w++;
                end
                chk("bp_valid_seen", a_out_valid, 1);
                for (int t = 0; t < 10; t++) begin
                    chk("bp_in_ready", a_in_ready, 0);
                    chk("bp_valid_held", a_out_valid, 1);
                    chk("bp_window_held", a_out_window, exp_win(0, 0, 0, 5, 12));
                    if (t < 9) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        settle();
        chk_seq(0, 0, 1, 5, 12, 12, 1);

        // Two back-to-back frames, second one offset by 1000.
        do_reset();
        sel = 0;
        drive(0, 288, 0);
        settle();
        chk_seq(0, 0, 2, 5, 12, 12, 1);

        // Reset after 30 pixels, then a full frame.
        do_reset();
        sel = 0;
        drive(0, 30, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", a_in_ready, 0);
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_window", a_out_window, 0);
        chk("midrst_row_col_last", {a_out_row, a_out_col, a_out_last}, 0);
        rst = 1'b0;
        drive(0, 144, 0);
        settle();
        chk_seq(0, 0, 1, 5, 12, 12, 1);

        // K=3, 8x6, random data with random in_valid/out_ready.
        do_reset();
        sel = 2;
        for (int k = 0; k < 48; k++) pix[k] = DB'($urandom_range(0, 4095));
        drive(0, 48, 1);
        settle();
        chk_seq(2, 0, 1, 3, 8, 6, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
